// File: rtl/carpma_seq_if.sv
// Start/done handshake bundle for the carpma_seq shift-add multiplier.
interface carpma_seq_if #(
    parameter int unsigned WIDTH = 8
);
    logic                   start;
    logic                   signed_mode;
    logic [WIDTH-1:0]       multiplicand;
    logic [WIDTH-1:0]       multiplier;
    logic [2*WIDTH-1:0]     product;
    logic                   busy;
    logic                   done;

    modport master (
        output start, signed_mode, multiplicand, multiplier,
        input  product, busy, done
    );

    modport slave (
        input  start, signed_mode, multiplicand, multiplier,
        output product, busy, done
    );
endinterface

// File: rtl/carpma_seq.sv
// Sequential shift-add multiplier, one partial product per clock, signed/unsigned per operation.
// Optional CARPMA_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are all zero.
module carpma_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    carpma_seq_if.slave   bus
);

    localparam int unsigned P_W   = 2 * WIDTH;
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [P_W-1:0]     p_q, p_d;
    logic               neg_q, neg_d;
    logic [P_W-1:0]     product_q, product_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifdef CARPMA_EARLY_EXIT_EN
    logic [WIDTH-1:0]   mrem_q, mrem_d;
`endif

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               neg_in;
    logic [WIDTH:0]     sum;
    logic [P_W-1:0]     p_step;
    logic [P_W-1:0]     p_final;
    logic               finish;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            mcand_q   <= '0;
            p_q       <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef CARPMA_EARLY_EXIT_EN
            mrem_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            p_q       <= p_d;
            neg_q     <= neg_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef CARPMA_EARLY_EXIT_EN
            mrem_q    <= mrem_d;
`endif
        end
    end

    // Operand magnitudes; two's-complement negate of the most negative value
    // yields 2^(WIDTH-1), which is exactly the unsigned magnitude we want.
    always_comb begin
        mag_a  = (bus.signed_mode && bus.multiplicand[WIDTH-1])
                 ? (~bus.multiplicand + WIDTH'(1)) : bus.multiplicand;
        mag_b  = (bus.signed_mode && bus.multiplier[WIDTH-1])
                 ? (~bus.multiplier + WIDTH'(1)) : bus.multiplier;
        neg_in = bus.signed_mode & (bus.multiplicand[WIDTH-1] ^ bus.multiplier[WIDTH-1]);
    end

    // One shift-add step on {acc, multiplier}; the carry lands in the top bit after the shift.
    always_comb begin
        sum    = {1'b0, p_q[P_W-1:WIDTH]} + (p_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        p_step = {sum, p_q[WIDTH-1:1]};
`ifdef CARPMA_EARLY_EXIT_EN
        finish  = (cnt_q == CNT_W'(WIDTH - 1)) || (mrem_q[WIDTH-1:1] == '0);
        p_final = p_step >> (CNT_W'(WIDTH - 1) - cnt_q);
`else
        finish  = (cnt_q == CNT_W'(WIDTH - 1));
        p_final = p_step;
`endif
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        p_d       = p_q;
        neg_d     = neg_q;
        product_d = product_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
`ifdef CARPMA_EARLY_EXIT_EN
        mrem_d    = mrem_q;
`endif

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    mcand_d = mag_a;
                    p_d     = {{WIDTH{1'b0}}, mag_b};
                    neg_d   = neg_in;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_CALC;
`ifdef CARPMA_EARLY_EXIT_EN
                    mrem_d  = mag_b;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                p_d   = p_step;
                cnt_d = cnt_q + CNT_W'(1);
`ifdef CARPMA_EARLY_EXIT_EN
                mrem_d = mrem_q >> 1;
`endif
                if (finish) begin
                    product_d = neg_q ? (~p_final + P_W'(1)) : p_final;
                    done_d    = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    busy_d    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.product = product_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_carpma_seq.sv
// Directed bench for carpma_seq at WIDTH=8 and WIDTH=4 with hand-computed products.
module tb_carpma_seq;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    carpma_seq_if #(.WIDTH(8)) bus8 ();
    carpma_seq_if #(.WIDTH(4)) bus4 ();

    carpma_seq #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));
    carpma_seq #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Edges from acceptance to done for a given multiplier magnitude.
    function automatic int exp_edges(input logic [7:0] mb);
`ifdef CARPMA_EARLY_EXIT_EN
        int hb;
        hb = 0;
        for (int i = 0; i < 8; i++) if (mb[i]) hb = i;
        return hb + 2;
`else
        return 9;
`endif
    endfunction

    function automatic logic [7:0] mag8(input logic sm, input logic [7:0] v);
        return (sm && v[7]) ? (~v + 8'd1) : v;
    endfunction

    // Count edges (including the one just coming) until done is seen, bounded.
    task automatic wait_done8(input bit drop_start, output int n, output int bc);
        n  = 0;
        bc = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (bus8.busy) bc++;
            if (drop_start) bus8.start = 1'b0;
        end while (!bus8.done && n < 40);
    endtask

    task automatic run_op8(input string tag, input logic sm, input logic [7:0] a,
                           input logic [7:0] b, input logic [15:0] exp_p);
        int n, bc, e;
        @(negedge clk);
        bus8.signed_mode  = sm;
        bus8.multiplicand = a;
        bus8.multiplier   = b;
        bus8.start        = 1'b1;
        wait_done8(1'b1, n, bc);
        e = exp_edges(mag8(sm, b));
        chk({tag, "_done"}, 64'(bus8.done), 64'(1));
        chk({tag, "_prod"}, 64'(bus8.product), 64'(exp_p));
        chk({tag, "_edges"}, 64'(n), 64'(e));
        chk({tag, "_busy"}, 64'(bc), 64'(e - 1));
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, 64'(bus8.done), 64'(0));
    endtask

    initial begin
        int n, m, bc;
        checks   = 0;
        failures = 0;
        rst = 1'b1;
        bus8.start = 1'b0; bus8.signed_mode = 1'b0; bus8.multiplicand = '0; bus8.multiplier = '0;
        bus4.start = 1'b0; bus4.signed_mode = 1'b0; bus4.multiplicand = '0; bus4.multiplier = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_prod", 64'(bus8.product), 64'(0));
        chk("rst_busy", 64'(bus8.busy), 64'(0));
        chk("rst_done", 64'(bus8.done), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        run_op8("u15x13",   1'b0, 8'd15,  8'd13,  16'h00C3);
        run_op8("u255x255", 1'b0, 8'd255, 8'd255, 16'hFE01);
        run_op8("sm128sq",  1'b1, 8'h80,  8'h80,  16'h4000);
        run_op8("sm7x6",    1'b1, 8'hF9,  8'd6,   16'hFFD6);
        run_op8("s0xm5",    1'b1, 8'd0,   8'hFB,  16'h0000);

        // WIDTH=4 unsigned corner
        @(negedge clk);
        bus4.multiplicand = 4'd15;
        bus4.multiplier   = 4'd15;
        bus4.start        = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            bus4.start = 1'b0;
        end while (!bus4.done && n < 40);
        chk("w4_prod", 64'(bus4.product), 64'(8'hE1));
        chk("w4_edges", 64'(n), 64'(5));

        // Back-to-back: start held through DONE
        @(negedge clk);
        bus8.signed_mode  = 1'b0;
        bus8.multiplicand = 8'd3;
        bus8.multiplier   = 8'd2;
        bus8.start        = 1'b1;
        wait_done8(1'b0, n, bc);
        chk("b2b1_prod", 64'(bus8.product), 64'(6));
        chk("b2b1_edges", 64'(n), 64'(exp_edges(8'd2)));
        bus8.multiplicand = 8'd9;
        bus8.multiplier   = 8'd7;
        wait_done8(1'b1, m, bc);
        chk("b2b2_done", 64'(bus8.done), 64'(1));
        chk("b2b2_prod", 64'(bus8.product), 64'(63));
        chk("b2b2_gap", 64'(m), 64'(exp_edges(8'd7)));
        @(posedge clk);
        #1;
        chk("b2b_pulse", 64'(bus8.done), 64'(0));

        // start pulsed mid-CALC is ignored
        @(negedge clk);
        bus8.signed_mode  = 1'b0;
        bus8.multiplicand = 8'd100;
        bus8.multiplier   = 8'd131;
        bus8.start        = 1'b1;
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        n = 1;
        repeat (2) begin
            @(posedge clk);
            #1;
            n++;
        end
        bus8.signed_mode  = 1'b1;
        bus8.multiplicand = 8'd7;
        bus8.multiplier   = 8'd7;
        bus8.start        = 1'b1;
        @(posedge clk);
        #1;
        n++;
        bus8.start = 1'b0;
        chk("mid_busy", 64'(bus8.busy), 64'(1));
        wait_done8(1'b1, m, bc);
        chk("mid_prod", 64'(bus8.product), 64'(13100));
        chk("mid_edges", 64'(n + m), 64'(9));
        @(posedge clk);
        #1;

        // Reset at CALC iteration 4 aborts
        @(negedge clk);
        bus8.signed_mode  = 1'b0;
        bus8.multiplicand = 8'd15;
        bus8.multiplier   = 8'hFD;
        bus8.start        = 1'b1;
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rstc_prod", 64'(bus8.product), 64'(0));
        chk("rstc_done", 64'(bus8.done), 64'(0));
        chk("rstc_busy", 64'(bus8.busy), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rstc_idle_busy", 64'(bus8.busy), 64'(0));
        chk("rstc_idle_done", 64'(bus8.done), 64'(0));
        chk("rstc_idle_prod", 64'(bus8.product), 64'(0));

        run_op8("post5x5", 1'b0, 8'd5, 8'd5, 16'd25);

`ifdef CARPMA_EARLY_EXIT_EN
        run_op8("ee200x1",   1'b0, 8'd200, 8'd1,   16'd200);
        run_op8("ee200x128", 1'b0, 8'd200, 8'h80,  16'd25600);
        run_op8("ee9x0",     1'b0, 8'd9,   8'd0,   16'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/carpma_seq.md
Name: carpma_seq

Overview:
- Parametrised sequential shift-add multiplier; next generation of the team's fixed 4x4 start/done multiplier.
- Adds configurable operand width, a per-operation signed/unsigned mode, a busy flag and back-to-back start acceptance.
- Sits as a shared arithmetic unit behind a simple start/done handshake. Intended for control-path and DSP helpers where area matters more than throughput.

Parameters:
- WIDTH, 8, operand width in bits. Legal range 2..32. Product width is 2*WIDTH.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE state.
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned. Latched with the operands.
- multiplicand  input  WIDTH  operand A; latched on an accepted start.
- multiplier  input  WIDTH  operand B; latched on an accepted start.
- product  output  2*WIDTH  result. Holds its value until the next completion.
- busy  output  1  high while state is CALC.
- done  output  1  one-cycle pulse; product is valid in that cycle.

Behaviour:
- Reset: rst high at a rising edge forces state=IDLE, product=0, busy=0, done=0, and clears internal registers.
  - Reset mid-CALC aborts the operation, produces no done pulse, and leaves product=0.
  - Reset has priority over start.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 at edge E0: latch operands and mode, cnt=0, go to CALC.
  - Otherwise stay in IDLE.
- Operand prep at acceptance:
  - Unsigned mode: magnitudes = operands as given.
  - Signed mode: magnitude = abs(operand) as a WIDTH-bit unsigned value. The most negative input (-2^(WIDTH-1)) gives magnitude 2^(WIDTH-1), which must be handled correctly.
  - neg_flag = sign(A) XOR sign(B) in signed mode, 0 in unsigned mode.
- CALC: one iteration per clock, WIDTH iterations total (edges E1..E_WIDTH).
  - If multiplier LSB=1: acc += multiplicand magnitude, aligned to the upper half.
  - Then shift {acc, multiplier} right by 1.
  - On the last iteration (cnt=WIDTH-1): product = neg_flag ? -acc_final : acc_final, done=1, go to DONE.
- DONE: lasts exactly one cycle, with done=1 and busy=0.
  - start=1 at that edge: accept new operands and go to CALC (back-to-back issue, no idle gap).
  - Otherwise go to IDLE.
- Latency: start sampled at E0 gives done high in the cycle after E_WIDTH, i.e. WIDTH+1 edges after acceptance.
  - Sustained throughput: one result per WIDTH+1 cycles.
- start while busy=1 is ignored: no queueing, no error, and in-flight operands are unaffected.
- Input changes while in CALC have no effect.
- Results:
  - Unsigned product is exact in 2*WIDTH bits.
  - Signed product is exact two's complement in 2*WIDTH bits, including (-2^(WIDTH-1))^2 = 2^(2*WIDTH-2).
  - Zero operands yield product=0 in both modes, with no negative zero.
- product changes only at the DONE-entry edge or on reset.

Optional Feature:
- Macro: CARPMA_EARLY_EXIT_EN.
- Defined:
  - In CALC, if the remaining (shifted) multiplier bits are all zero, skip the remaining iterations.
  - Finish the alignment shift in the same edge, then go to DONE.
  - Minimum latency is 2 edges after acceptance (multiplier=0 or 1). Maximum is still WIDTH+1.
  - Product values are identical to the non-early-exit build.
- Undefined: fixed WIDTH+1 latency regardless of operand values.

Test Plan:
- WIDTH=8, unsigned, 15 x 13 -> product=195 (0x00C3). done pulses exactly 1 cycle, 9 edges after start. busy high for 8 cycles.
- WIDTH=8, unsigned, 255 x 255 -> 65025 (0xFE01). WIDTH=4, unsigned, 15 x 15 -> 225 (0xE1).
- WIDTH=8, signed:
  - -128 x -128 -> 16384 (0x4000).
  - -7 x 6 -> -42 (0xFFD6).
  - 0 x -5 -> 0.
- Back-to-back: start held high through DONE with 3 x 2 then 9 x 7 -> done pulses 9 cycles apart; products 6 then 63.
- Protocol:
  - start pulsed mid-CALC with different operands -> ignored; first result correct.
  - rst asserted at CALC iteration 4 -> no done pulse, product=0, IDLE next cycle.
  - New start after reset -> completes correctly.
- With CARPMA_EARLY_EXIT_EN, WIDTH=8:
  - 200 x 1 -> done 2 edges after start, product 200.
  - 200 x 0x80 -> 9 edges, product 25600.
